// File: rtl/tracking_arbiter_if.sv
// Channel-array and loops-side signals of the tracking arbiter.
// master = channels + loops instance, slave = the arbiter.
interface tracking_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int HIST_WIDTH   = 128,
  parameter int RES_WIDTH    = 96
);
  logic [NUM_CHANNELS-1:0]            req;
  logic [NUM_CHANNELS*HIST_WIDTH-1:0] hist_in;
  logic                               loop_start;
  logic [HIST_WIDTH-1:0]              loop_hist;
  logic                               loop_ready;
  logic [RES_WIDTH-1:0]               loop_result;
  logic [NUM_CHANNELS-1:0]            result_valid;
  logic [RES_WIDTH-1:0]               result_out;
  logic [3:0]                         grant_id;
  logic                               busy;
  logic [NUM_CHANNELS-1:0]            overrun;
  logic                               timeout_err;

  modport master (
    output req, hist_in, loop_ready, loop_result,
    input  loop_start, loop_hist, result_valid, result_out, grant_id, busy, overrun, timeout_err
  );

  modport slave (
    input  req, hist_in, loop_ready, loop_result,
    output loop_start, loop_hist, result_valid, result_out, grant_id, busy, overrun, timeout_err
  );
endinterface

// File: rtl/tracking_arbiter.sv
// Shares one tracking_loops datapath across NUM_CHANNELS correlator channels:
// buffers each channel's dump, grants round-robin, launches the loops, waits
// for completion (with abort) and routes the registered result back.

// Per-channel request slot: newest history plus a pending flag.
module tracking_arbiter_slot #(
  parameter int HIST_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  req,
  input  logic                  clr,
  input  logic [HIST_WIDTH-1:0] hist,
  output logic                  pending,
  output logic                  overrun,
  output logic [HIST_WIDTH-1:0] hist_q
);
  // A new request always wins over a same-cycle grant clear; a request landing
  // on a still-queued one (not the one being granted now) is an overrun.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      hist_q  <= '0;
    end else begin
      overrun <= req && pending && !clr;
      if (req) begin
        hist_q  <= hist;
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

module tracking_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int HIST_WIDTH   = 128,
  parameter int RES_WIDTH    = 96,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                global_reset_n,
  tracking_arbiter_if.slave   bus
);
  localparam logic [3:0] PTR_RST = 4'(NUM_CHANNELS - 1);
  // Last WAIT cycle index before abort: WAIT lasts at most TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t                                 state;
  logic [3:0]                             ptr;
  logic [7:0]                             cnt;
  logic [NUM_CHANNELS-1:0]                pending;
  logic [NUM_CHANNELS-1:0]                clr;
  logic [NUM_CHANNELS-1:0]                overrun_q;
  logic [NUM_CHANNELS-1:0][HIST_WIDTH-1:0] slot_hist;
  logic                                   win_vld;
  logic [3:0]                             win_id;
  logic [HIST_WIDTH-1:0]                  win_hist;
  logic [NUM_CHANNELS-1:0]                gnt_oh;

  logic                    loop_start_q;
  logic [HIST_WIDTH-1:0]   loop_hist_q;
  logic [NUM_CHANNELS-1:0] result_valid_q;
  logic [RES_WIDTH-1:0]    result_out_q;
  logic [3:0]              grant_id_q;
  logic                    busy_q;
  logic                    timeout_err_q;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_slot
    tracking_arbiter_slot #(.HIST_WIDTH(HIST_WIDTH)) u_slot (
      .clk            (clk),
      .global_reset_n (global_reset_n),
      .req            (bus.req[g]),
      .clr            (clr[g]),
      .hist           (bus.hist_in[g*HIST_WIDTH +: HIST_WIDTH]),
      .pending        (pending[g]),
      .overrun        (overrun_q[g]),
      .hist_q         (slot_hist[g])
    );
  end

  // Round-robin pick: lowest pending index above ptr, else lowest at/below ptr.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (pending[i] && i <= int'(ptr)) begin
        win_vld = 1'b1;
        win_id  = 4'(i);
      end
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (pending[i] && i > int'(ptr)) begin
        win_vld = 1'b1;
        win_id  = 4'(i);
      end
  end

  // Winner history mux, grant clear to the slots, one-hot of the served channel.
  always_comb begin
    win_hist = '0;
    clr      = '0;
    gnt_oh   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (win_id == 4'(i)) begin
        win_hist = slot_hist[i];
        clr[i]   = (state == IDLE) && win_vld;
      end
      if (grant_id_q == 4'(i)) gnt_oh[i] = 1'b1;
    end
  end

  // Service FSM; every strobe is registered on the transition into its state.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state          <= IDLE;
      ptr            <= PTR_RST;
      cnt            <= '0;
      loop_start_q   <= 1'b0;
      loop_hist_q    <= '0;
      result_valid_q <= '0;
      result_out_q   <= '0;
      grant_id_q     <= '0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      loop_start_q   <= 1'b0;
      result_valid_q <= '0;
      timeout_err_q  <= 1'b0;
      case (state)
        IDLE: if (win_vld) begin
          loop_hist_q  <= win_hist;
          grant_id_q   <= win_id;
          ptr          <= win_id;
          loop_start_q <= 1'b1;
          busy_q       <= 1'b1;
          state        <= LAUNCH;
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (bus.loop_ready) begin
          result_out_q   <= bus.loop_result;
          result_valid_q <= gnt_oh;
          state          <= DONE;
        end else if (cnt == TO_LAST) begin
          // Abort: the request is dropped, not requeued.
          timeout_err_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= IDLE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.loop_start   = loop_start_q;
  assign bus.loop_hist    = loop_hist_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_out   = result_out_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_tracking_arbiter.sv
// Directed bench for tracking_arbiter: transaction-level reference model
// compared every cycle, plus hand-computed checks per scenario.
module tb_tracking_arbiter;
  localparam int NC = 4;
  localparam int HW = 128;
  localparam int RW = 96;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tracking_arbiter_if #(.NUM_CHANNELS(NC), .HIST_WIDTH(HW), .RES_WIDTH(RW)) bus ();

  tracking_arbiter #(.NUM_CHANNELS(NC), .HIST_WIDTH(HW), .RES_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .global_reset_n (rst_n),
    .bus            (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- loops stand-in ----------------
  logic          man_rdy = 1'b0;
  logic [RW-1:0] man_res = '0;
  logic          auto_rdy = 1'b0;
  logic [RW-1:0] auto_res = '0;
  logic [RW-1:0] last_auto_res = '0;
  logic [7:0]    resp_tag = '0;
  int            resp_delay = 0;
  int            resp_cnt = 0;

  assign bus.loop_ready  = man_rdy | auto_rdy;
  assign bus.loop_result = man_rdy ? man_res : auto_res;

  // Answers resp_delay cycles after each loop_start (0 = never answers).
  always @(negedge clk) begin
    auto_rdy = 1'b0;
    if (resp_cnt == 1) begin
      auto_rdy = 1'b1;
      resp_tag = resp_tag + 8'd1;
      auto_res = {32'hC0DE0000, 56'h0, resp_tag};
      last_auto_res = auto_res;
    end
    if (resp_cnt > 0) resp_cnt--;
    if (rst_n && bus.loop_start && resp_delay > 0) resp_cnt = resp_delay;
  end

  // ---------------- event monitor ----------------
  int         cyc = 0;
  logic [3:0] gq[$];
  logic [HW-1:0] hq[$];
  int n_valid = 0, n_over = 0, n_over2 = 0;
  int start_cyc = 0, tout_cyc = 0;
  bit tout_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.loop_start) begin
        gq.push_back(bus.grant_id);
        hq.push_back(bus.loop_hist);
        start_cyc = cyc;
      end
      if (bus.result_valid != '0) n_valid++;
      if (bus.overrun != '0) n_over++;
      if (bus.overrun[2]) n_over2++;
      if (bus.timeout_err) begin
        tout_cyc  = cyc;
        tout_seen = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  // A job is granted from the pending set, spends one launch cycle, then waits
  // (age counts wait cycles) until answered or TO wait cycles have elapsed;
  // an answered job spends one delivery cycle before the arbiter is free.
  bit            m_pend[NC];
  logic [HW-1:0] m_buf[NC];
  int            m_ptr, m_owner, m_age, mw;
  bit            m_active, m_answered, mg;
  logic          e_start, e_busy, e_tout;
  logic [NC-1:0] e_valid, e_over;
  logic [HW-1:0] e_hist;
  logic [RW-1:0] e_res;
  logic [3:0]    e_gid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_pend[c] = 1'b0;
        m_buf[c]  = '0;
      end
      m_ptr = NC - 1; m_owner = 0; m_age = 0; m_active = 0; m_answered = 0;
      e_start = 0; e_busy = 0; e_tout = 0; e_valid = '0; e_over = '0;
      e_hist = '0; e_res = '0; e_gid = '0;
    end else begin
      e_start = 0; e_valid = '0; e_tout = 0; e_over = '0;
      mg = 0; mw = 0;
      if (!m_active)
        for (int off = 1; off <= NC; off++)
          if (!mg && m_pend[(m_ptr + off) % NC]) begin
            mg = 1;
            mw = (m_ptr + off) % NC;
          end
      for (int c = 0; c < NC; c++)
        e_over[c] = bus.req[c] && m_pend[c] && !(mg && mw == c);
      if (!m_active) begin
        if (mg) begin
          m_active = 1; m_answered = 0; m_age = 0; m_owner = mw; m_ptr = mw;
          m_pend[mw] = 0;
          e_hist = m_buf[mw]; e_gid = 4'(mw); e_start = 1; e_busy = 1;
        end
      end else if (m_answered) begin
        m_active = 0; e_busy = 0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (bus.loop_ready) begin
        m_answered = 1; e_res = bus.loop_result; e_valid[m_owner] = 1'b1;
      end else if (m_age == TO) begin
        m_active = 0; e_tout = 1; e_busy = 0;
      end else begin
        m_age++;
      end
      for (int c = 0; c < NC; c++)
        if (bus.req[c]) begin
          m_buf[c]  = bus.hist_in[c*HW +: HW];
          m_pend[c] = 1'b1;
        end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("loop_start",   bus.loop_start,   e_start);
      chk("loop_hist",    bus.loop_hist,    e_hist);
      chk("result_valid", bus.result_valid, e_valid);
      chk("result_out",   bus.result_out,   e_res);
      chk("grant_id",     bus.grant_id,     e_gid);
      chk("busy",         bus.busy,         e_busy);
      chk("overrun",      bus.overrun,      e_over);
      chk("timeout_err",  bus.timeout_err,  e_tout);
    end
  end

  task automatic set_hist(input int c, input logic [HW-1:0] v);
    bus.hist_in[c*HW +: HW] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, bus.loop_start,   1'b0);
    chk({tag, "_hist"},  bus.loop_hist,    '0);
    chk({tag, "_valid"}, bus.result_valid, '0);
    chk({tag, "_res"},   bus.result_out,   '0);
    chk({tag, "_gid"},   bus.grant_id,     '0);
    chk({tag, "_busy"},  bus.busy,         1'b0);
    chk({tag, "_ovr"},   bus.overrun,      '0);
    chk({tag, "_tout"},  bus.timeout_err,  1'b0);
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int k = 0;
    while (n_valid < target && k < budget) begin
      step();
      k++;
    end
    chk(name, 128'(n_valid), 128'(target));
  endtask

  initial begin
    logic [HW-1:0] h0, h1, hx, ha, hb;
    int base;
    h0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    h1 = 128'h1010_2020_3030_4040_5050_6060_7070_8080;
    hx = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000;
    ha = 128'h0000_0000_0000_0000_0000_0000_0000_00A0;
    hb = 128'h0000_0000_0000_0000_0000_0000_0000_00B0;
    bus.req = '0;
    bus.hist_in = '0;

    // Reset state
    repeat (2) step();
    #1 chk_all_zero("rst");
    step();
    rst_n = 1'b1;
    step();

    // Single request on channel 0, loops answer at t+5
    set_hist(0, h0);
    bus.req = 4'b0001;
    step(); bus.req = '0;                         // t+1
    step();                                       // t+2
    chk("single_start", bus.loop_start, 1'b1);
    chk("single_hist",  bus.loop_hist,  h0);
    chk("single_gid",   bus.grant_id,   4'd0);
    chk("single_busy",  bus.busy,       1'b1);
    step(); step(); step();                       // t+5
    man_res = 96'hABC;
    man_rdy = 1'b1;
    step(); man_rdy = 1'b0;                       // t+6
    chk("single_valid", bus.result_valid, 4'b0001);
    chk("single_res",   bus.result_out,   96'hABC);
    step();                                       // t+7
    chk("single_valid_off", bus.result_valid, 4'b0000);
    chk("single_res_hold",  bus.result_out,   96'hABC);
    chk("single_idle",      bus.busy,         1'b0);

    // Reset asserted mid-WAIT
    resp_delay = 0;
    set_hist(1, h1);
    bus.req = 4'b0010;
    step(); bus.req = '0;
    step(); step(); step();
    chk("rstw_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rstw");
    step(); step();
    rst_n = 1'b1;
    base = n_valid;
    repeat (4) step();
    chk("rstw_no_valid", 128'(n_valid), 128'(base));

    // Fairness: all four request together, answered 3 cycles after each start
    resp_delay = 3;
    gq.delete(); hq.delete();
    base = n_valid;
    for (int c = 0; c < NC; c++) set_hist(c, 128'(32'h100 * (c + 1)));
    step();
    bus.req = 4'b1111;
    step(); bus.req = '0;
    wait_valid(base + 4, 60, "fair_valids");
    chk("fair_ngrants", 128'(gq.size()), 128'd4);
    if (gq.size() == 4) begin
      chk("fair_g0", gq[0], 4'd0);
      chk("fair_g1", gq[1], 4'd1);
      chk("fair_g2", gq[2], 4'd2);
      chk("fair_g3", gq[3], 4'd3);
      chk("fair_h3", hq[3], 128'h400);
    end
    chk("fair_no_overrun", 128'(n_over), 128'd0);

    // Overrun: channel 2 re-requests (data B) while channel 0 waits
    step();
    gq.delete(); hq.delete();
    base = n_valid;
    set_hist(0, hx);
    set_hist(2, ha);
    bus.req = 4'b0101;                            // t
    step(); bus.req = '0;                         // t+1
    step();                                       // t+2
    step();                                       // t+3, ch0 in WAIT
    set_hist(2, hb);
    bus.req = 4'b0100;
    step(); bus.req = '0;                         // t+4
    chk("ovr_pulse", bus.overrun, 4'b0100);
    wait_valid(base + 2, 60, "ovr_valids");
    chk("ovr_count", 128'(n_over2), 128'd1);
    chk("ovr_ngrants", 128'(gq.size()), 128'd2);
    if (gq.size() == 2) begin
      chk("ovr_g0", gq[0], 4'd0);
      chk("ovr_g1", gq[1], 4'd2);
      chk("ovr_hist_b", hq[1], hb);
    end

    // Timeout: loops never answer
    step(); step();
    resp_delay = 0;
    base = n_valid;
    tout_seen = 1'b0;
    bus.req = 4'b0010;
    step(); bus.req = '0;
    begin
      int k = 0;
      while (!tout_seen && k < 400) begin
        step();
        k++;
      end
    end
    chk("tout_seen", tout_seen, 1'b1);
    chk("tout_dist", 128'(tout_cyc - start_cyc), 128'd256);
    step();
    chk("tout_idle", bus.busy, 1'b0);
    chk("tout_no_valid", 128'(n_valid), 128'(base));

    // Stray loop_ready in IDLE
    step();
    man_res = 96'hDEAD;
    man_rdy = 1'b1;
    step(); man_rdy = 1'b0;
    step();
    chk("stray_valid", bus.result_valid, 4'b0000);
    chk("stray_res",   bus.result_out,   last_auto_res);
    chk("stray_idle",  bus.busy,         1'b0);
    chk("stray_no_valid", 128'(n_valid), 128'(base));
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
